// File: rtl/cpu_gen2_pkg.sv
// Shared types and field positions for the cpu_gen2 core.
// Holds the opcode and state enums plus instruction layout constants.
package cpu_gen2_pkg;

  localparam int INSTR_W = 16;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 11;
  localparam int RD_HI  = 10;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 2;
  localparam int RS_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_MOV  = 5'd1,
    OP_MVI  = 5'd2,
    OP_ADD  = 5'd3,
    OP_SUB  = 5'd4,
    OP_AND  = 5'd5,
    OP_OR   = 5'd6,
    OP_XOR  = 5'd7,
    OP_INC  = 5'd8,
    OP_NOT  = 5'd9,
    OP_ROR  = 5'd10,
    OP_ROL  = 5'd11,
    OP_JMP  = 5'd12,
    OP_JNC  = 5'd13,
    OP_JZ   = 5'd14,
    OP_CALL = 5'd15,
    OP_RET  = 5'd16,
    OP_HALT = 5'd17
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/cpu_gen2_stack.sv
// Return-address LIFO, PC_W bits wide and DEPTH entries deep.
// Ports: push/pop strobes, din/dout (top of stack), full/empty.
module cpu_gen2_stack
  import cpu_gen2_pkg::*;
#(
  parameter int PC_W  = 4,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] dout,
  output logic            full,
  output logic            empty
);

  localparam int SP_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0] mem_q [DEPTH];
  logic [PC_W-1:0] mem_d [DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;

  assign full  = (sp_q == SP_W'(DEPTH));
  assign empty = (sp_q == '0);

  // sp counts entries, so the top lives at sp-1
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) dout = mem_q[i];
    end
  end

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    if (push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sp_q == SP_W'(i)) mem_d[i] = din;
      end
      sp_d = sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cpu_gen2.sv
// Parametrised accumulator/register CPU with req/ack instruction fetch.
// Ports: clk, reset(n), btn->r5, led<-r6, pc, imem_*, halted, stack_err, retire.
module cpu_gen2
  import cpu_gen2_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int PC_W        = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  btn,
  output logic [DATA_W-1:0]  led,
  output logic [PC_W-1:0]    pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               halted,
  output logic               stack_err,
  output logic               retire
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                c_q, c_d;
  logic                z_q, z_d;
  logic                serr_q, serr_d;
  logic [DATA_W-1:0]   regs_q [8];
  logic [DATA_W-1:0]   regs_d [8];

  opcode_e             op;
  logic [2:0]          rd, rs;
  logic [DATA_W-1:0]   a, b, imm_d;
  logic [PC_W-1:0]     imm_pc, pc_inc;
  logic [DATA_W-1:0]   res;
  logic [DATA_W:0]     wide;
  logic                wr, setz;
  logic                push, pop, full, empty;
  logic [PC_W-1:0]     stk_dout;

  assign op     = opcode_e'(ir_q[OP_HI:OP_LO]);
  assign rd     = ir_q[RD_HI:RD_LO];
  assign rs     = ir_q[RS_HI:RS_LO];
  assign a      = regs_q[rd];
  assign b      = regs_q[rs];
  assign imm_d  = DATA_W'(ir_q[IMM_HI:IMM_LO]);
  assign imm_pc = PC_W'(ir_q[IMM_HI:IMM_LO]);
  assign pc_inc = pc_q + PC_W'(1);

  cpu_gen2_stack #(
    .PC_W  (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_dout),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    c_d     = c_q;
    z_d     = z_q;
    serr_d  = serr_q;
    regs_d  = regs_q;
    res     = a;
    wide    = '0;
    wr      = 1'b0;
    setz    = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        case (op)
          OP_MOV: begin res = b; wr = 1'b1; end
          OP_MVI: begin res = imm_d; wr = 1'b1; end
          OP_ADD: begin
            wide = {1'b0, a} + {1'b0, b};
            res  = wide[DATA_W-1:0];
            c_d  = wide[DATA_W];
            wr   = 1'b1;
            setz = 1'b1;
          end
          // top bit of the widened difference is the borrow
          OP_SUB: begin
            wide = {1'b0, a} - {1'b0, b};
            res  = wide[DATA_W-1:0];
            c_d  = wide[DATA_W];
            wr   = 1'b1;
            setz = 1'b1;
          end
          OP_AND: begin res = a & b; wr = 1'b1; setz = 1'b1; end
          OP_OR:  begin res = a | b; wr = 1'b1; setz = 1'b1; end
          OP_XOR: begin res = a ^ b; wr = 1'b1; setz = 1'b1; end
          OP_INC: begin
            wide = {1'b0, a} + (DATA_W+1)'(1);
            res  = wide[DATA_W-1:0];
            c_d  = wide[DATA_W];
            wr   = 1'b1;
            setz = 1'b1;
          end
          OP_NOT: begin res = ~a; wr = 1'b1; setz = 1'b1; end
          OP_ROR: begin
            res  = {a[0], a[DATA_W-1:1]};
            wr   = 1'b1;
            setz = 1'b1;
          end
          OP_ROL: begin
            res  = {a[DATA_W-2:0], a[DATA_W-1]};
            wr   = 1'b1;
            setz = 1'b1;
          end
          OP_JMP: pc_d = imm_pc;
          OP_JNC: begin
            if (!c_q) pc_d = imm_pc;
            c_d = 1'b0;
          end
          OP_JZ: begin
            if (z_q) pc_d = imm_pc;
          end
          OP_CALL: begin
            if (full) serr_d = 1'b1;
            else begin
              push = 1'b1;
              pc_d = imm_pc;
            end
          end
          OP_RET: begin
            if (empty) serr_d = 1'b1;
            else begin
              pop  = 1'b1;
              pc_d = stk_dout;
            end
          end
          OP_HALT: state_d = ST_HALT;
          default: ;
        endcase
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
    if (wr)   regs_d[rd] = res;
    if (setz) z_d = (res == '0);
    // button port owns r5 every cycle, overriding any write
    regs_d[5] = btn;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      serr_q  <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
      z_q     <= z_d;
      serr_q  <= serr_d;
      regs_q  <= regs_d;
    end
  end

  assign led       = regs_q[6];
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign imem_req  = (state_q == ST_FETCH);
  assign halted    = (state_q == ST_HALT);
  assign retire    = (state_q == ST_EXEC);
  assign stack_err = serr_q;

endmodule

// File: tb/tb_cpu_gen2.sv
// Self-checking bench for cpu_gen2 (DATA_W=4, PC_W=4, STACK_DEPTH=1).
// Program vectors feed a halt-time scoreboard; corner cases run by hand.
module tb_cpu_gen2;
  import cpu_gen2_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  btn = 4'h0;
  logic [3:0]  led;
  logic [3:0]  pc;
  logic        imem_req;
  logic [3:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0;
  logic        halted;
  logic        stack_err;
  logic        retire;

  cpu_gen2 #(
    .DATA_W      (4),
    .PC_W        (4),
    .STACK_DEPTH (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .led       (led),
    .pc        (pc),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .halted    (halted),
    .stack_err (stack_err),
    .retire    (retire)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] led;
    logic [3:0] pc;
    logic       serr;
    int         nret;
  } exp_t;

  typedef struct {
    string      name;
    logic [3:0] btn;
    int         dly;
    logic [3:0] led;
    logic [3:0] pc;
    logic       serr;
    int         nret;
  } vec_t;

  localparam int NV = 9;

  int          n_vec = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  vec_t        vecs[NV];
  logic [15:0] progs[NV][12];
  logic [15:0] mem[16];
  int          cur_dly = 0;
  logic        force_ack = 1'b0;
  logic [15:0] force_data = 16'h0;
  int          wcnt = 0;
  logic [15:0] hlt;

  function automatic logic [15:0] enc(opcode_e op, int rd, int imm);
    return {op, rd[2:0], imm[7:0]};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // instruction memory with programmable ack latency
  always @(negedge clk) begin
    if (force_ack) begin
      imem_ack  = 1'b1;
      imem_data = force_data;
      wcnt      = 0;
    end else if (!reset) begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end else if (imem_req && wcnt >= cur_dly) begin
      imem_ack  = 1'b1;
      imem_data = mem[imem_addr];
      wcnt      = 0;
    end else begin
      imem_ack = 1'b0;
      if (imem_req) wcnt++;
    end
  end

  int         cyc = 0;
  int         last_ret = -1;
  int         ret_cnt = 0;
  logic       prev_req = 1'b0;
  logic [3:0] prev_addr = 4'h0;
  logic       prev_halt = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!reset) begin
      last_ret  = -1;
      ret_cnt   = 0;
      prev_req  = 1'b0;
      prev_halt = 1'b0;
    end else begin
      if (retire) begin
        if (last_ret >= 0)
          chk("retire_gap", 32'(cyc - last_ret), 32'(2 + cur_dly));
        last_ret = cyc;
        ret_cnt++;
      end
      if (prev_req && imem_req)
        chk("addr_hold", 32'(imem_addr), 32'(prev_addr));
      if (halted && !prev_halt) begin
        chk("halt_after_retire", 32'(cyc - last_ret), 32'd1);
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd1, 32'(sb.size()));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_led"}, 32'(led), 32'(e.led));
          chk({e.name, "_pc"}, 32'(pc), 32'(e.pc));
          chk({e.name, "_serr"}, 32'(stack_err), 32'(e.serr));
          chk({e.name, "_nret"}, 32'(ret_cnt), 32'(e.nret));
        end
      end
      prev_req  = imem_req;
      prev_addr = imem_addr;
      prev_halt = halted;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
  endtask

  task automatic wait_halt(string nm);
    for (int k = 0; k < 600; k++) begin
      @(posedge clk);
      #2;
      if (halted) return;
    end
    n_vec++;
    n_bad++;
    $display("FAIL %s: no halt within 600 cycles", nm);
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic run_vec(int i);
    exp_t e;
    @(posedge clk);
    #3;
    cur_dly = vecs[i].dly;
    btn     = vecs[i].btn;
    for (int a = 0; a < 16; a++) mem[a] = (a < 12) ? progs[i][a] : hlt;
    e.name = vecs[i].name;
    e.led  = vecs[i].led;
    e.pc   = vecs[i].pc;
    e.serr = vecs[i].serr;
    e.nret = vecs[i].nret;
    sb.push_back(e);
    do_reset();
    wait_halt(vecs[i].name);
  endtask

  initial begin
    exp_t e;
    int   got;
    hlt = enc(OP_HALT, 0, 0);

    progs[0] = '{enc(OP_MVI,0,9), enc(OP_MVI,1,8), enc(OP_ADD,0,1),
                 enc(OP_JNC,0,0), enc(OP_MOV,6,0), enc(OP_JNC,0,7),
                 enc(OP_MVI,6,15), hlt, hlt, hlt, hlt, hlt};
    progs[1] = '{enc(OP_MVI,0,3), enc(OP_MVI,1,5), enc(OP_SUB,0,1),
                 enc(OP_JZ,0,6), enc(OP_JNC,0,6), enc(OP_MOV,6,0),
                 hlt, hlt, hlt, hlt, hlt, hlt};
    progs[2] = '{enc(OP_MVI,2,12), enc(OP_MVI,3,10), enc(OP_AND,2,3),
                 enc(OP_OR,2,3), enc(OP_XOR,2,3), enc(OP_JZ,0,8),
                 enc(OP_MVI,6,1), hlt, enc(OP_MVI,4,6),
                 enc(OP_AND,4,3), enc(OP_MOV,6,4), hlt};
    progs[3] = '{enc(OP_MVI,0,8'h3F), enc(OP_INC,0,0), enc(OP_JZ,0,4),
                 hlt, enc(OP_MVI,1,9), enc(OP_ROR,1,0), enc(OP_ROL,1,0),
                 enc(OP_ROL,1,0), enc(OP_NOT,1,0), enc(OP_JNC,0,11),
                 enc(OP_MOV,6,1), hlt};
    progs[4] = '{enc(OP_ADD,6,1), enc(OP_JNC,0,3), enc(OP_MVI,6,1),
                 enc(OP_JZ,0,5), enc(OP_MVI,6,2), hlt,
                 hlt, hlt, hlt, hlt, hlt, hlt};
    progs[5] = '{enc(OP_MVI,5,3), enc(OP_MOV,0,5), enc(OP_MOV,6,0),
                 hlt, hlt, hlt, hlt, hlt, hlt, hlt, hlt, hlt};
    progs[6] = '{enc(OP_CALL,0,4), enc(OP_MOV,6,0), enc(OP_RET,0,0),
                 hlt, enc(OP_MVI,0,7), enc(OP_CALL,0,9), enc(OP_RET,0,0),
                 hlt, hlt, hlt, hlt, hlt};
    progs[7] = '{enc(OP_CALL,0,3), enc(OP_MOV,6,0), hlt,
                 enc(OP_MVI,0,5), enc(OP_RET,0,0),
                 hlt, hlt, hlt, hlt, hlt, hlt, hlt};
    progs[8] = progs[0];

    vecs[0] = '{"add_jnc",    4'h0, 0, 4'h1, 4'h8, 1'b0, 7};
    vecs[1] = '{"sub_jz",     4'h0, 0, 4'he, 4'h7, 1'b0, 7};
    vecs[2] = '{"logic",      4'h0, 0, 4'h2, 4'hc, 1'b0, 10};
    vecs[3] = '{"shift",      4'h0, 0, 4'hc, 4'hc, 1'b0, 11};
    vecs[4] = '{"rst_state",  4'h0, 0, 4'h0, 4'h6, 1'b0, 4};
    vecs[5] = '{"btn_r5",     4'ha, 0, 4'ha, 4'h4, 1'b0, 4};
    vecs[6] = '{"stack_err",  4'h0, 0, 4'h7, 4'h4, 1'b1, 7};
    vecs[7] = '{"call_ret",   4'h0, 1, 4'h5, 4'h3, 1'b0, 5};
    vecs[8] = '{"slow_fetch", 4'h0, 3, 4'h1, 4'h8, 1'b0, 7};

    for (int a = 0; a < 16; a++) mem[a] = hlt;

    // reset state while reset is held from time zero
    @(posedge clk);
    #2;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_serr", 32'(stack_err), 32'd0);

    for (int i = 0; i < NV; i++) run_vec(i);

    // branch at the top of the PC space wraps to 0
    @(posedge clk);
    #3;
    cur_dly = 0;
    btn     = 4'h0;
    for (int a = 0; a < 16; a++) mem[a] = hlt;
    mem[0]  = enc(OP_JMP, 0, 15);
    mem[15] = enc(OP_JZ, 0, 5);
    do_reset();
    got = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #2;
      if (ret_cnt >= 2) begin
        got = 1;
        break;
      end
    end
    chk("wrap_reached", 32'(got), 32'd1);
    @(posedge clk);
    #2;
    chk("wrap_pc", 32'(pc), 32'd0);
    chk("wrap_addr", 32'(imem_addr), 32'd0);

    // HALT holds against a stuck-high ack; only reset leaves it
    @(posedge clk);
    #3;
    for (int a = 0; a < 16; a++) mem[a] = hlt;
    e = '{"halt0", 4'h0, 4'h1, 1'b0, 1};
    sb.push_back(e);
    do_reset();
    wait_halt("halt0");
    @(posedge clk);
    #3;
    force_data = enc(OP_MVI, 6, 15);
    force_ack  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #2;
      chk("halt_hold", 32'(halted), 32'd1);
      chk("halt_noreq", 32'(imem_req), 32'd0);
    end
    chk("halt_led", 32'(led), 32'd0);
    #1 reset = 1'b0;
    @(posedge clk);
    #2;
    chk("hrst_pc", 32'(pc), 32'd0);
    chk("hrst_req", 32'(imem_req), 32'd1);
    chk("hrst_halted", 32'(halted), 32'd0);
    chk("hrst_retire", 32'(retire), 32'd0);
    chk("hrst_led", 32'(led), 32'd0);
    #1;
    reset     = 1'b1;
    force_ack = 1'b0;
    cur_dly   = 5;

    // reset in the middle of a slow fetch, ack high during reset
    @(posedge clk);
    @(posedge clk);
    #3;
    reset     = 1'b0;
    force_ack = 1'b1;
    @(posedge clk);
    #3;
    reset     = 1'b1;
    force_ack = 1'b0;
    e = '{"midfetch", 4'h0, 4'h1, 1'b0, 1};
    sb.push_back(e);
    @(posedge clk);
    #2;
    chk("mf_retire", 32'(retire), 32'd0);
    chk("mf_req", 32'(imem_req), 32'd1);
    chk("mf_pc", 32'(pc), 32'd0);
    wait_halt("midfetch");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_gen2.md
Name: cpu_gen2

Overview:
- Second-generation parametrised accumulator/register CPU core for the LED boards.
- Generalises the 4-bit 8-register core:
  - configurable data and PC widths;
  - a dedicated PC, no longer a GPR;
  - a zero flag;
  - a return stack for CALL/RET;
  - HALT.
- Fetches 16-bit instructions from an external instruction memory over a req/ack handshake, so slow BSRAM or flash ROMs are supported.
- Button input and LED output stay mapped to r5/r6. Matrix scanning stays outside this block.

Parameters:
- DATA_W, 4, register/ALU width; legal range 4..8.
- PC_W, 4, program counter width; legal range 4..8.
- STACK_DEPTH, 4, return stack entries; legal range 1..16.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- btn  in  DATA_W  button input, sampled into r5 every cycle
- led  out  DATA_W  mirror of r6
- pc  out  PC_W  current program counter
- imem_req  out  1  fetch request, high in FETCH state
- imem_addr  out  PC_W  fetch address, equals pc
- imem_ack  in  1  instruction valid this cycle
- imem_data  in  16  instruction word
- halted  out  1  core in HALT state
- stack_err  out  1  sticky: CALL on full stack or RET on empty stack
- retire  out  1  one-cycle pulse per executed instruction

Behaviour:
- Reset (reset low at posedge clk):
  - r0..r7, pc, C, Z, stack pointer, stack_err = 0; state = FETCH.
  - Outputs after reset: led=0, pc=0, halted=0, retire=0, imem_req=1.
  - imem_ack is ignored while reset is low.
  - Reset mid-fetch abandons the fetch; the next fetch is from address 0.
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack, latch imem_data into IR and go to EXEC. Otherwise hold; there is no timeout.
  - EXEC: exactly one cycle. Execute IR, pulse retire, update pc. Go to FETCH, or to HALT for the HALT opcode.
  - HALT: halted=1, imem_req=0. Only reset exits.
- Latency: minimum 2 cycles per instruction (ack in the same cycle as req).
- IR fields:
  - op = IR[15:11]
  - rd = IR[10:8]
  - rs = IR[2:0]
  - imm = IR[7:0]; truncated to DATA_W for data, to PC_W for targets.
- Opcodes (ALU results are modulo 2^DATA_W):
  - 00000 NOP
  - 00001 MOV rd<=rs
  - 00010 MVI rd<=imm
  - 00011 ADD rd<=rd+rs; C = carry out of bit DATA_W-1
  - 00100 SUB rd<=rd-rs; C = borrow
  - 00101 AND, 00110 OR, 00111 XOR: rd<=rd op rs; C unchanged
  - 01000 INC rd; C = carry out
  - 01001 NOT rd
  - 01010 ROR rd; 01011 ROL rd (1-bit rotate over DATA_W)
  - 01100 JMP imm
  - 01101 JNC: pc<=imm if C=0, else pc+1; C cleared afterwards
  - 01110 JZ: pc<=imm if Z=1, else pc+1
  - 01111 CALL: push pc+1, pc<=imm
  - 10000 RET: pc<=pop
  - 10001 HALT
  - All other opcodes execute as NOP.
- Flags:
  - Z is updated by every opcode that writes rd, except MOV and MVI: Z = (result==0).
  - C is changed only by ADD, SUB, INC and JNC.
- pc:
  - Non-jump instructions: pc<=pc+1, wrapping to 0 at 2^PC_W-1.
  - Untaken branches also take pc+1.
  - CALL pushes pc+1, with the same wrap.
- r5:
  - r5<=btn every cycle. A same-cycle instruction write to r5 is overridden by btn.
  - Reads of r5 return the value registered on the previous cycle.
- r6 drives led directly as a registered output.
- Stack boundaries:
  - CALL with the stack full: no push, stack_err<=1, pc<=pc+1.
  - RET with the stack empty: stack_err<=1, pc<=pc+1.
  - stack_err clears only on reset.
- HALT retires (retire pulses) in its EXEC cycle; halted rises the following cycle.

Decomposition:
- cpu_gen2_pkg holds:
  - opcode enum (5-bit);
  - state enum FETCH/EXEC/HALT;
  - INSTR_W=16;
  - field position localparams.
- One sub-module: cpu_gen2_stack, a parametrised LIFO of PC_W×STACK_DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Same clk/reset convention as the core.

Test Plan:
- MVI r0,9; MVI r1,8; ADD r0,r1 (DATA_W=4), ack immediate -> r0=1, C=1, Z=0; JNC 0 then falls through to pc=4 with C=0; retire pulses every 2nd cycle.
- imem_ack delayed 3 cycles per fetch -> imem_req held with stable imem_addr; no retire until ack; each instruction takes 5 cycles.
- Two nested CALLs with STACK_DEPTH=1 -> first pushes; second sets stack_err=1 and falls through to pc+1; RET returns to the first return address; a further RET keeps stack_err=1 and goes to pc+1.
- Branch at address 15 with PC_W=4, JZ untaken (Z=0) -> pc wraps to 0.
- btn=4'hA, MOV r0,r5; MOV r6,r0 -> led=4'hA; MVI r5,3 has no lasting effect (r5 tracks btn).
- HALT, then reset pulse mid-FETCH with imem_ack high -> halted=1 and imem_req=0 until reset; after reset pc=0, imem_req=1, all registers and led 0.
